// File: rtl/jtgng_prom_loader_if.sv
// Download-side byte stream into the PROM loader and the PROM write port out of it.
interface jtgng_prom_loader_if #(
   parameter int AW = 8,
   parameter int DW = 4
);
   logic          downloading;
   logic [21:0]   ioctl_addr;
   logic [7:0]    ioctl_data;
   logic          ioctl_wr;
   logic [3:0]    prom_we;
   logic [AW-1:0] prom_addr;
   logic [DW-1:0] prom_data;
   logic          loaded;
   logic [AW+2:0] wr_count;

   // Drives the download stream and observes the PROM port.
   modport master (
      output downloading, ioctl_addr, ioctl_data, ioctl_wr,
      input  prom_we, prom_addr, prom_data, loaded, wr_count
   );

   // The loader itself.
   modport slave (
      input  downloading, ioctl_addr, ioctl_data, ioctl_wr,
      output prom_we, prom_addr, prom_data, loaded, wr_count
   );
endinterface

// File: rtl/jtgng_prom_loader.sv
// Splits a 4*2**AW byte window of the ROM download stream into four small PROMs.
// Each accepted byte produces a one-cycle write pulse on the PROM selected by the
// two offset bits above the PROM address; loaded reports whether the last
// download delivered a full window's worth of writes.
module jtgng_prom_loader #(
   parameter int          AW    = 8,
   parameter int          DW    = 4,
   parameter logic [21:0] START = 22'h0_8000
) (
   input  logic               clk,
   input  logic               rst_n,
   jtgng_prom_loader_if.slave bus
);
   localparam int unsigned   NBYTES   = 4 * (2**AW);
   localparam logic [22:0]   END_ADDR = {1'b0, START} + 23'(NBYTES);
   localparam logic [AW+2:0] FULL     = {1'b1, {(AW+2){1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t        state_q,     state_d;
   logic          wr_last_q,   wr_last_d;
   logic [3:0]    prom_we_q,   prom_we_d;
   logic [AW-1:0] prom_addr_q, prom_addr_d;
   logic [DW-1:0] prom_data_q, prom_data_d;
   logic          loaded_q,    loaded_d;
   logic [AW+2:0] wr_count_q,  wr_count_d;

   logic [AW+1:0] off;
   logic          in_range;
   logic          wr_rise;
   logic          accept;
   logic [AW+2:0] cnt_inc;

   // Write acceptance, PROM port update and download state tracking.
   always_comb begin
      // Only the low AW+2 offset bits matter; modular subtraction keeps them exact.
      off      = bus.ioctl_addr[AW+1:0] - START[AW+1:0];
      in_range = ({1'b0, bus.ioctl_addr} >= {1'b0, START}) &&
                 ({1'b0, bus.ioctl_addr} < END_ADDR);
      wr_rise  = bus.ioctl_wr & ~wr_last_q;
      accept   = wr_rise && (state_q == LOAD) && bus.downloading && in_range;
      cnt_inc  = (accept && (wr_count_q != FULL)) ? wr_count_q + (AW+3)'(1) : wr_count_q;

      state_d     = state_q;
      wr_last_d   = bus.ioctl_wr;
      prom_we_d   = '0;
      prom_addr_d = prom_addr_q;
      prom_data_d = prom_data_q;
      loaded_d    = loaded_q;
      wr_count_d  = wr_count_q;

      if (accept) begin
         prom_we_d[off[AW+1:AW]] = 1'b1;
         prom_addr_d             = off[AW-1:0];
         prom_data_d             = bus.ioctl_data[DW-1:0];
      end

      case (state_q)
         IDLE, DONE: begin
            // Writes on the entry edge are dropped: accept needs state LOAD.
            if (bus.downloading) begin
               state_d    = LOAD;
               wr_count_d = '0;
               loaded_d   = 1'b0;
            end
         end
         LOAD: begin
            wr_count_d = cnt_inc;
            if (!bus.downloading) begin
               state_d  = DONE;
               loaded_d = (cnt_inc == FULL);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any download in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_last_q   <= 1'b0;
         prom_we_q   <= '0;
         prom_addr_q <= '0;
         prom_data_q <= '0;
         loaded_q    <= 1'b0;
         wr_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_last_q   <= wr_last_d;
         prom_we_q   <= prom_we_d;
         prom_addr_q <= prom_addr_d;
         prom_data_q <= prom_data_d;
         loaded_q    <= loaded_d;
         wr_count_q  <= wr_count_d;
      end
   end

   assign bus.prom_we   = prom_we_q;
   assign bus.prom_addr = prom_addr_q;
   assign bus.prom_data = prom_data_q;
   assign bus.loaded    = loaded_q;
   assign bus.wr_count  = wr_count_q;
endmodule

// File: tb/tb_jtgng_prom_loader.sv
// Bench for jtgng_prom_loader: directed vector table, corner sequences and
// randomized download sessions checked against an address-window model.
module tb_jtgng_prom_loader;
   localparam int AW     = 8;
   localparam int DW     = 4;
   localparam int START  = 32'h8000;
   localparam int NBYTES = 4 << AW;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   jtgng_prom_loader_if #(.AW(AW), .DW(DW)) bus ();

   jtgng_prom_loader #(.AW(AW), .DW(DW), .START(22'h0_8000)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } pulse_t;

   typedef struct {
      int unsigned addr;
      int unsigned data;
      int          hold;
      logic [3:0]  we;
      logic [7:0]  pa;
      logic [3:0]  pd;
      int          cnt;
   } vec_t;

   pulse_t     got_q[$];
   pulse_t     exp_q[$];
   bit         mon_en = 1'b0;
   logic [3:0] prev_we = 4'b0;
   vec_t       vecs[8];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic bit in_win(input int unsigned a);
      return (a >= START) && (a < START + NBYTES);
   endfunction

   // Expected PROM write for a byte at download address a.
   function automatic pulse_t model_pulse(input int unsigned a, input int unsigned d);
      pulse_t      p;
      int unsigned off;
      off  = a - START;
      p.we = 4'(1 << (off / (2**AW)));
      p.a  = AW'(off % (2**AW));
      p.d  = DW'(d % (2**DW));
      return p;
   endfunction

   task automatic drive_write(input int unsigned a, input int unsigned d, input int hold, input int gap);
      bus.ioctl_addr = 22'(a);
      bus.ioctl_data = 8'(d);
      bus.ioctl_wr   = 1'b1;
      tick(hold);
      bus.ioctl_wr   = 1'b0;
      tick(gap);
   endtask

   // Collect every PROM write pulse; each must be one-hot and last one cycle.
   always @(negedge clk) begin
      if (mon_en && bus.prom_we != 4'b0) begin
         got_q.push_back('{bus.prom_we, bus.prom_addr, bus.prom_data});
         check("pulse_onehot", $countones(bus.prom_we), 1);
         check("pulse_width", prev_we, 0);
      end
      prev_we <= bus.prom_we;
   end

   task automatic run_session(input int n, input int mode, input string tag);
      int unsigned a;
      int unsigned d;
      int          cnt;
      int          nb;
      int          per_bit[4];
      cnt = 0;
      bus.downloading = 1'b1;
      tick(1);
      check({tag, " wr_count_entry"}, bus.wr_count, 0);
      check({tag, " loaded_entry"}, bus.loaded, 0);
      got_q.delete();
      exp_q.delete();
      mon_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (mode == 0)
            a = START + (i % NBYTES);
         else if (mode == 2 && $urandom_range(9) == 0)
            a = ($urandom_range(1) == 1) ? START - 1 - $urandom_range(15)
                                         : START + NBYTES + $urandom_range(15);
         else
            a = START + $urandom_range(NBYTES - 1);
         d = (mode == 0) ? (a % 256) : $urandom_range(255);
         if (in_win(a)) begin
            exp_q.push_back(model_pulse(a, d));
            if (cnt < NBYTES) cnt++;
         end
         if (mode == 0) drive_write(a, d, 1, 1);
         else drive_write(a, d, $urandom_range(1, 3), $urandom_range(1, 2));
      end
      tick(2);
      bus.downloading = 1'b0;
      tick(2);
      mon_en = 1'b0;
      check({tag, " wr_count"}, bus.wr_count, cnt);
      check({tag, " loaded"}, bus.loaded, (cnt == NBYTES) ? 1 : 0);
      check({tag, " pulse_total"}, got_q.size(), exp_q.size());
      nb = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < nb; i++)
         check({tag, " pulse_seq"}, {got_q[i].we, got_q[i].a, got_q[i].d},
               {exp_q[i].we, exp_q[i].a, exp_q[i].d});
      if (mode == 0) begin
         per_bit = '{0, 0, 0, 0};
         foreach (got_q[i])
            for (int b = 0; b < 4; b++)
               if (got_q[i].we[b]) per_bit[b]++;
         for (int b = 0; b < 4; b++)
            check({tag, " pulses_per_prom"}, per_bit[b], 2**AW);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h8234, 32'hAB, 1, 4'b0100, 8'h34, 4'hB, 1};
      vecs[1] = '{32'h8000, 32'h5A, 5, 4'b0001, 8'h00, 4'hA, 2};
      vecs[2] = '{32'h7FFF, 32'h11, 1, 4'b0000, 8'h00, 4'hA, 2};
      vecs[3] = '{32'h8400, 32'h22, 1, 4'b0000, 8'h00, 4'hA, 2};
      vecs[4] = '{32'h83FF, 32'hFF, 2, 4'b1000, 8'hFF, 4'hF, 3};
      vecs[5] = '{32'h8100, 32'h3C, 1, 4'b0010, 8'h00, 4'hC, 4};
      vecs[6] = '{32'h8100, 32'h3D, 3, 4'b0010, 8'h00, 4'hD, 5};
      vecs[7] = '{32'h80FF, 32'h96, 1, 4'b0001, 8'hFF, 4'h6, 6};

      rst_n           = 1'b0;
      bus.downloading = 1'b0;
      bus.ioctl_addr  = '0;
      bus.ioctl_data  = '0;
      bus.ioctl_wr    = 1'b0;
      tick(3);
      check("reset prom_we", bus.prom_we, 0);
      check("reset prom_addr", bus.prom_addr, 0);
      check("reset prom_data", bus.prom_data, 0);
      check("reset loaded", bus.loaded, 0);
      check("reset wr_count", bus.wr_count, 0);
      rst_n = 1'b1;
      tick(2);

      // Strobe arriving on the same edge downloading rises is dropped.
      bus.ioctl_addr  = 22'h8010;
      bus.ioctl_data  = 8'h77;
      bus.ioctl_wr    = 1'b1;
      bus.downloading = 1'b1;
      tick(1);
      check("entry_drop prom_we", bus.prom_we, 0);
      tick(1);
      check("entry_drop held prom_we", bus.prom_we, 0);
      bus.ioctl_wr = 1'b0;
      tick(1);
      check("entry_drop wr_count", bus.wr_count, 0);

      // Directed vectors inside one download.
      for (int i = 0; i < 8; i++) begin
         bus.ioctl_addr = 22'(vecs[i].addr);
         bus.ioctl_data = 8'(vecs[i].data);
         bus.ioctl_wr   = 1'b1;
         tick(1);
         check($sformatf("vec%0d prom_we", i), bus.prom_we, vecs[i].we);
         check($sformatf("vec%0d prom_addr", i), bus.prom_addr, vecs[i].pa);
         check($sformatf("vec%0d prom_data", i), bus.prom_data, vecs[i].pd);
         if (vecs[i].hold > 1) begin
            tick(vecs[i].hold - 1);
            check($sformatf("vec%0d held_strobe prom_we", i), bus.prom_we, 0);
         end
         bus.ioctl_wr = 1'b0;
         tick(1);
         check($sformatf("vec%0d prom_we_after", i), bus.prom_we, 0);
         check($sformatf("vec%0d addr_hold", i), bus.prom_addr, vecs[i].pa);
         check($sformatf("vec%0d data_hold", i), bus.prom_data, vecs[i].pd);
         check($sformatf("vec%0d wr_count", i), bus.wr_count, vecs[i].cnt);
      end
      bus.downloading = 1'b0;
      tick(2);
      check("vec_done loaded", bus.loaded, 0);
      check("vec_done wr_count", bus.wr_count, 6);

      run_session(NBYTES, 0, "full");
      run_session(NBYTES - 1, 1, "partial");
      run_session(1300, 2, "mixed");
      run_session(200, 2, "short");

      // Reset in the middle of a download with a strobe pending.
      bus.downloading = 1'b1;
      tick(1);
      for (int i = 0; i < 500; i++) drive_write(START + i, i, 1, 1);
      check("pre_reset wr_count", bus.wr_count, 500);
      check("pre_reset prom_addr", bus.prom_addr, 499 % 256);
      check("pre_reset prom_data", bus.prom_data, 499 % 16);
      bus.ioctl_addr = 22'(START + 3);
      bus.ioctl_data = 8'h55;
      bus.ioctl_wr   = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check("async_reset prom_we", bus.prom_we, 0);
      check("async_reset prom_addr", bus.prom_addr, 0);
      check("async_reset prom_data", bus.prom_data, 0);
      check("async_reset loaded", bus.loaded, 0);
      check("async_reset wr_count", bus.wr_count, 0);
      tick(1);
      check("in_reset pending lost", bus.prom_we, 0);
      bus.ioctl_wr = 1'b0;
      rst_n = 1'b1;
      tick(1);
      check("post_reset wr_count", bus.wr_count, 0);
      drive_write(START + 32'h205, 32'h3E, 1, 1);
      check("post_reset wr_count_after_write", bus.wr_count, 1);
      check("post_reset prom_addr", bus.prom_addr, 8'h05);
      check("post_reset prom_data", bus.prom_data, 4'hE);
      bus.downloading = 1'b0;
      tick(2);
      check("post_reset loaded", bus.loaded, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jtgng_prom_loader.md
JTGNG_PROM_LOADER -- requirements
Module: jtgng_prom_loader

Interface
REQ-001 SHALL have parameter AW, default 8: address width of each target PROM (2**AW entries).
REQ-002 SHALL have parameter DW, default 4: PROM data width.
REQ-003 SHALL have parameter START, default 22'h0_8000: first download byte address of the PROM region.
REQ-004 SHALL have port clk  in  1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port downloading  in  1: high while a ROM download is in progress.
REQ-007 SHALL have port ioctl_addr  in  22: byte address of the current download byte.
REQ-008 SHALL have port ioctl_data  in  8: current download byte.
REQ-009 SHALL have port ioctl_wr  in  1: write strobe, one or more cycles high per byte.
REQ-010 SHALL have port prom_we  out  4: one-hot write enable, one bit per PROM.
REQ-011 SHALL have port prom_addr  out  AW: write address to the PROMs.
REQ-012 SHALL have port prom_data  out  DW: write data to the PROMs.
REQ-013 SHALL have port loaded  out  1: all 4*2**AW bytes were received in the last completed download.
REQ-014 SHALL have port wr_count  out  AW+3: accepted-write count for the current or last download.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-016 IDLE->LOAD and DONE->LOAD SHALL occur when downloading=1; the same edge SHALL clear wr_count and loaded.
REQ-017 LOAD->DONE SHALL occur when downloading=0.
REQ-018 SHALL stay in IDLE or DONE while downloading=0.
REQ-019 SHALL detect ioctl_wr rising edges against a registered copy (reset 0); a strobe held high several cycles SHALL count as one write.
REQ-020 A write SHALL be accepted only on an ioctl_wr rising edge while state=LOAD, downloading=1 and START <= ioctl_addr < START+4*2**AW.
REQ-021 Writes in the cycle downloading rises (state still IDLE/DONE) SHALL be dropped.
REQ-022 On an accepted write, with off=ioctl_addr-START, the next rising edge SHALL set:
- prom_we[off[AW+1:AW]]=1
- prom_addr=off[AW-1:0]
- prom_data=ioctl_data[DW-1:0]
REQ-023 Write latency SHALL be one clock from the accepting edge.
REQ-024 prom_we SHALL be high for exactly one cycle per accepted write and zero otherwise.
REQ-025 prom_addr and prom_data SHALL hold their values until the next accepted write.
REQ-026 wr_count SHALL increment on each accepted write, including rewrites of the same address.
REQ-027 wr_count SHALL saturate at 4*2**AW.
REQ-028 Out-of-range or rejected writes SHALL not change any output.
REQ-029 On the LOAD->DONE transition, loaded SHALL be set to (wr_count==4*2**AW), evaluated after any same-cycle increment.
REQ-030 loaded SHALL hold until the next LOAD entry or reset.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE; prom_we, prom_addr, prom_data, loaded, wr_count and the ioctl_wr edge register SHALL all be 0.
REQ-032 Reset mid-download SHALL abort it; a pending write SHALL be lost.
REQ-033 After reset release with downloading=1, the block SHALL enter LOAD on the next edge.

Verification
REQ-034 Full load: downloading=1, then 1024 strobes at addresses 0x8000..0x83FF with data=addr[7:0], then downloading=0 -> 256 one-cycle pulses on each prom_we bit in order; wr_count=1024; loaded=1.
REQ-035 Region decode: single write to 0x8234, data 0xAB -> one clock later prom_we=4'b0100, prom_addr=0x34, prom_data=0xB.
REQ-036 Out-of-range writes to 0x7FFF and 0x8400 -> prom_we stays 0, wr_count unchanged.
REQ-037 ioctl_wr held high 5 cycles at 0x8000 -> exactly one prom_we pulse; wr_count=1.
REQ-038 Partial load: 1023 bytes, then downloading=0 -> loaded=0; a second download clears wr_count on entry.
REQ-039 Reset: rst_n pulsed low after byte 500 -> all outputs 0 asynchronously; with downloading still high the block re-enters LOAD and wr_count restarts from 0.
